// File: rtl/io_bus_device.sv
// rtl/io_bus_device.sv - CPU IO-bus peripheral: LED register, synchronized switch/button capture, display output port
// All register state updates on clk; io_din is a combinational read mux over io_addr.
module io_bus_device #(
  parameter int LED_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       io_addr,
  input  logic [31:0]      io_dout,
  input  logic             io_we,
  output logic [31:0]      io_din,
  input  logic [LED_W-1:0] sw,
  input  logic             btn,
  output logic [LED_W-1:0] led,
  output logic [31:0]      out_data,
  output logic             out_vld,
  input  logic             out_ack
);

  localparam logic [7:0] ADDR_LED        = 8'h00;
  localparam logic [7:0] ADDR_IN_STATUS  = 8'h04;
  localparam logic [7:0] ADDR_IN_DATA    = 8'h08;
  localparam logic [7:0] ADDR_OUT_STATUS = 8'h0C;
  localparam logic [7:0] ADDR_OUT_DATA   = 8'h10;
  localparam logic [7:0] ADDR_OVR_CNT    = 8'h14;

  logic [LED_W-1:0] led_q, led_d;
  logic [LED_W-1:0] sw_m_q, sw_s_q;
  logic             btn_m_q, btn_s_q, btn_prev_q;
  logic [1:0]       sync_fill_q;
  logic             armed_q, armed_d;
  logic [LED_W-1:0] in_data_q, in_data_d;
  logic             in_vld_q, in_vld_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_vld_q, out_vld_d;
  logic [7:0]       ovr_q, ovr_d;

  logic wr_led, wr_ack, wr_out, wr_ovr_clr, btn_edge;

  assign wr_led     = io_we && (io_addr == ADDR_LED);
  assign wr_ack     = io_we && (io_addr == ADDR_IN_STATUS);
  assign wr_out     = io_we && (io_addr == ADDR_OUT_DATA);
  assign wr_ovr_clr = io_we && (io_addr == ADDR_OVR_CNT);

  // Edges count only once the synchronized button has been seen low after
  // reset, so a button held through reset release is not taken as a press.
  assign btn_edge = armed_q && btn_s_q && !btn_prev_q;
  assign armed_d  = armed_q || (sync_fill_q[1] && !btn_s_q);

  always_comb begin
    led_d      = led_q;
    in_data_d  = in_data_q;
    in_vld_d   = in_vld_q;
    out_data_d = out_data_q;
    out_vld_d  = out_vld_q;
    ovr_d      = ovr_q;

    if (wr_led) begin
      led_d = io_dout[LED_W-1:0];
    end

    // A same-cycle ack frees the slot, so the new capture is not an overrun.
    if (btn_edge && (!in_vld_q || wr_ack)) begin
      in_data_d = sw_s_q;
      in_vld_d  = 1'b1;
    end else if (btn_edge) begin
      if (ovr_q != 8'hFF) begin
        ovr_d = ovr_q + 8'd1;
      end
    end else if (wr_ack) begin
      in_vld_d = 1'b0;
    end

    if (wr_ovr_clr) begin
      ovr_d = 8'h00;
    end

    if (out_vld_q && out_ack) begin
      out_vld_d = 1'b0;
    end else if (!out_vld_q && wr_out) begin
      out_data_d = io_dout;
      out_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q       <= '0;
      sw_m_q      <= '0;
      sw_s_q      <= '0;
      btn_m_q     <= 1'b0;
      btn_s_q     <= 1'b0;
      btn_prev_q  <= 1'b0;
      sync_fill_q <= 2'b00;
      armed_q     <= 1'b0;
      in_data_q   <= '0;
      in_vld_q    <= 1'b0;
      out_data_q  <= '0;
      out_vld_q   <= 1'b0;
      ovr_q       <= '0;
    end else begin
      led_q       <= led_d;
      sw_m_q      <= sw;
      sw_s_q      <= sw_m_q;
      btn_m_q     <= btn;
      btn_s_q     <= btn_m_q;
      btn_prev_q  <= btn_s_q;
      sync_fill_q <= {sync_fill_q[0], 1'b1};
      armed_q     <= armed_d;
      in_data_q   <= in_data_d;
      in_vld_q    <= in_vld_d;
      out_data_q  <= out_data_d;
      out_vld_q   <= out_vld_d;
      ovr_q       <= ovr_d;
    end
  end

  always_comb begin
    io_din = 32'h0;
    case (io_addr)
      ADDR_LED:        io_din = 32'(led_q);
      ADDR_IN_STATUS:  io_din = {31'b0, in_vld_q};
      ADDR_IN_DATA:    io_din = 32'(in_data_q);
      ADDR_OUT_STATUS: io_din = {31'b0, ~out_vld_q};
      ADDR_OUT_DATA:   io_din = out_data_q;
      ADDR_OVR_CNT:    io_din = {24'b0, ovr_q};
      default:         io_din = 32'h0;
    endcase
  end

  assign led      = led_q;
  assign out_data = out_data_q;
  assign out_vld  = out_vld_q;

endmodule

// File: tb/tb_io_bus_device.sv
// tb/tb_io_bus_device.sv - directed self-checking bench for io_bus_device
module tb_io_bus_device;

  logic        clk;
  logic        rst;
  logic [7:0]  io_addr;
  logic [31:0] io_dout;
  logic        io_we;
  logic [31:0] io_din;
  logic [7:0]  sw;
  logic        btn;
  logic [7:0]  led;
  logic [31:0] out_data;
  logic        out_vld;
  logic        out_ack;

  int n_checks = 0;
  int n_err    = 0;

  io_bus_device #(.LED_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .io_addr  (io_addr),
    .io_dout  (io_dout),
    .io_we    (io_we),
    .io_din   (io_din),
    .sw       (sw),
    .btn      (btn),
    .led      (led),
    .out_data (out_data),
    .out_vld  (out_vld),
    .out_ack  (out_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    io_addr = a;
    @(negedge clk);
    chk(tag, io_din, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    io_addr = a;
    io_dout = d;
    io_we   = 1'b1;
    tick();
    io_we   = 1'b0;
  endtask

  task automatic press(input logic [7:0] v);
    sw  = v;
    btn = 1'b1;
    repeat (3) tick();
    btn = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1; io_addr = 8'h00; io_dout = 32'h0; io_we = 1'b0;
    sw = 8'h00; btn = 1'b0; out_ack = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    chk("rst_led", {24'b0, led}, 32'h0);
    chk("rst_out_vld", {31'b0, out_vld}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    rd("rst_in_status", 8'h04, 32'h0);
    rd("rst_out_status", 8'h0C, 32'h1);
    rd("rst_ovr", 8'h14, 32'h0);

    wr(8'h00, 32'h000000A5);
    chk("led_a5", {24'b0, led}, 32'hA5);
    rd("rd_led", 8'h00, 32'hA5);
    wr(8'h08, 32'h000000EE);
    rd("ro_in_data", 8'h08, 32'h0);
    rd("unmapped", 8'h18, 32'h0);

    press(8'h3C);
    rd("in_vld_set", 8'h04, 32'h1);
    rd("in_data_3c", 8'h08, 32'h3C);
    wr(8'h04, 32'h0);
    rd("in_vld_ack", 8'h04, 32'h0);

    press(8'h11);
    press(8'h22);
    rd("ovr_keep", 8'h08, 32'h11);
    rd("ovr_cnt1", 8'h14, 32'h1);
    wr(8'h14, 32'h0);
    rd("ovr_clr", 8'h14, 32'h0);
    press(8'h33);
    rd("ovr_cnt_again", 8'h14, 32'h1);

    // Ack write lands in the cycle the synchronized edge is active.
    sw  = 8'h55;
    btn = 1'b1;
    tick();
    tick();
    io_addr = 8'h04; io_we = 1'b1;
    tick();
    io_we = 1'b0;
    btn   = 1'b0;
    repeat (3) tick();
    rd("coinc_vld", 8'h04, 32'h1);
    rd("coinc_data", 8'h08, 32'h55);
    rd("coinc_ovr", 8'h14, 32'h1);

    wr(8'h10, 32'hDEADBEEF);
    chk("out_vld_set", {31'b0, out_vld}, 32'h1);
    rd("out_busy", 8'h0C, 32'h0);
    rd("out_readback", 8'h10, 32'hDEADBEEF);
    wr(8'h10, 32'h12345678);
    chk("out_hold", out_data, 32'hDEADBEEF);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    chk("out_acked", {31'b0, out_vld}, 32'h0);
    rd("out_ready", 8'h0C, 32'h1);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    chk("ack_idle", {31'b0, out_vld}, 32'h0);
    wr(8'h10, 32'h0000AAAA);
    io_addr = 8'h10; io_dout = 32'h0000BBBB; io_we = 1'b1; out_ack = 1'b1;
    tick();
    io_we = 1'b0; out_ack = 1'b0;
    chk("ack_wr_vld", {31'b0, out_vld}, 32'h0);
    chk("ack_wr_data", out_data, 32'h0000AAAA);

    wr(8'h00, 32'h000000FF);
    wr(8'h10, 32'h00000077);
    chk("pre_rst_vld", {31'b0, out_vld}, 32'h1);
    btn = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    io_addr = 8'h00; io_dout = 32'h0000005A; io_we = 1'b1;
    tick();
    io_we = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst2_led", {24'b0, led}, 32'h0);
    chk("rst2_vld", {31'b0, out_vld}, 32'h0);
    chk("rst2_data", out_data, 32'h0);
    rd("rst2_in_data", 8'h08, 32'h0);
    repeat (6) tick();
    rd("held_no_edge", 8'h04, 32'h0);
    rd("held_ovr", 8'h14, 32'h0);
    btn = 1'b0;
    repeat (3) tick();
    sw  = 8'h9A;
    btn = 1'b1;
    repeat (4) tick();
    rd("retoggle_edge", 8'h04, 32'h1);
    rd("retoggle_data", 8'h08, 32'h9A);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/io_bus_device.md
IO_BUS_DEVICE -- requirements
Module: io_bus_device

Interface
REQ-001 SHALL have parameter LED_W, default 8, width of the LED register and switch input.
REQ-002 SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port io_addr, input, 8, CPU IO bus byte address.
REQ-005 SHALL have port io_dout, input, 32, CPU-to-device write data.
REQ-006 SHALL have port io_we, input, 1, CPU write strobe, one cycle per write.
REQ-007 SHALL have port io_din, output, 32, device-to-CPU read data.
REQ-008 SHALL have port sw, input, LED_W, switch value, asynchronous to clk.
REQ-009 SHALL have port btn, input, 1, input-commit button, asynchronous and level.
REQ-010 SHALL have port led, output, LED_W, LED register contents.
REQ-011 SHALL have port out_data, output, 32, display data register.
REQ-012 SHALL have port out_vld, output, 1, display data pending.
REQ-013 SHALL have port out_ack, input, 1, display consumer acknowledge pulse.

Function
REQ-014 SHALL implement the register map: 0x00 LED (R/W), 0x04 IN_STATUS (R; write acks), 0x08 IN_DATA (R), 0x0C OUT_STATUS (R), 0x10 OUT_DATA (W, reads back), 0x14 OVR_CNT (R; write clears).
REQ-015 SHALL drive io_din combinationally from io_addr in the same cycle, zero-extended; unmapped addresses read 0.
REQ-016 SHALL ignore writes to unmapped or read-only addresses (0x08, 0x0C).
REQ-017 SHALL set led to io_dout[LED_W-1:0] on the clock after io_we with io_addr=0x00.
REQ-018 SHALL pass sw and btn through two-flop synchronizers; sw_s is captured 2 cycles after a change.
REQ-019 SHALL detect a btn rising edge as a one-cycle pulse when the synchronized btn is 1 and its prior registered value is 0.
REQ-020 SHALL, on an edge with in_vld=0, latch sw_s into in_data and set in_vld on the next clock.
REQ-021 SHALL, on an edge with in_vld=1, keep in_data and increment OVR_CNT (8-bit, saturating at 0xFF).
REQ-022 SHALL return {31'b0, in_vld} at 0x04; any io_we to 0x04 clears in_vld.
REQ-023 SHALL, when an ack write and an edge occur in the same cycle, capture the new sw_s and leave in_vld=1 without counting an overrun.
REQ-024 SHALL, on io_we to 0x10 with out_vld=0, load out_data=io_dout and set out_vld=1.
REQ-025 SHALL ignore writes to 0x10 while out_vld=1, leaving out_data unchanged.
REQ-026 SHALL clear out_vld on out_ack=1 while out_vld=1; out_ack with out_vld=0 has no effect.
REQ-027 SHALL, when out_ack and a 0x10 write coincide with out_vld=1, clear out_vld and discard the write.
REQ-028 SHALL return {31'b0, ~out_vld} at 0x0C, meaning ready.
REQ-029 SHALL clear OVR_CNT to 0 on any io_we to 0x14; this takes priority over a same-cycle increment.

Reset
REQ-030 SHALL, with rst=1 at a clock edge, clear led, in_data, in_vld, out_data, out_vld, OVR_CNT, synchronizer flops and edge history.
REQ-031 SHALL give rst priority over all writes, edges and acks in the same cycle; io_din reflects reset state on the following cycle.
REQ-032 SHALL NOT report a button held high through reset release as an edge until btn falls and rises again.

Verification
REQ-033 SHALL check: write 0x00 with 0x000000A5 -> led=0xA5 next cycle, and 0x00 reads 0xA5.
REQ-034 SHALL check: sw=0x3C, btn pulse -> within 4 cycles 0x04 reads 1 and 0x08 reads 0x3C; write 0x04 -> 0x04 reads 0.
REQ-035 SHALL check: two btn pulses without ack (sw 0x11 then 0x22) -> 0x08 reads 0x11 and 0x14 reads 1; write 0x14 -> 0x14 reads 0.
REQ-036 SHALL check: write 0x10 with 0xDEADBEEF -> out_vld=1 and 0x0C reads 0; write 0x10 with 0x12345678 -> out_data stays 0xDEADBEEF; out_ack -> out_vld=0 and 0x0C reads 1.
REQ-037 SHALL check: ack write to 0x04 and a btn edge in the same cycle with sw=0x55 -> in_vld=1, 0x08 reads 0x55, OVR_CNT unchanged.
REQ-038 SHALL check: rst asserted with out_vld=1, led=0xFF and btn held high -> all outputs 0; no edge until btn toggles.
